lcd12864_frame_ctrl: RTL and testbench

- Upstream sequencer for the 12864 SPI LCD path; sole driver of the serial byte writer's Start_Sig/SPI_Data/Done_Sig handshake.
- After reset it:
  1. pulses the panel hardware reset;
  2. issues the fixed ST7565 init command list;
  3. streams a full 8-page x 128-column frame from an external display memory.
- Afterwards, each Refresh_Sig request rewrites the whole frame.

---
 rtl/lcd12864_frame_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd12864_frame_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd12864_frame_ctrl.sv
// lcd12864_frame_ctrl: panel reset, ST7565 init and full-frame streaming
// for the 12864 SPI LCD. It is the only requester of the byte writer.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   Refresh_Sig           frame rewrite request (pulse or level)
//   Busy, Frame_Done      status; Frame_Done pulses once per frame
//   LCD_RSTn              panel hardware reset, active-low
//   Mem_Addr, Mem_Data    display memory {page,col}; data one cycle later
//   Start_Sig, SPI_Data   writer request and {CS_n, A0, byte}
//   Done_Sig              writer completion pulse
module lcd12864_frame_ctrl #(
   parameter int RST_LOW_CYC  = 50000,
   parameter int RST_WAIT_CYC = 250000,
   parameter int DLY_W        = 18
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Refresh_Sig,
   output logic       Busy,
   output logic       Frame_Done,
   output logic       LCD_RSTn,
   output logic [9:0] Mem_Addr,
   input  logic [7:0] Mem_Data,
   output logic       Start_Sig,
   output logic [9:0] SPI_Data,
   input  logic       Done_Sig
);

   typedef enum logic [2:0] {
      HW_RST,
      HW_WAIT,
      INIT_CMD,
      PAGE_CMD,
      FETCH,
      DATA,
      FRAME_END,
      IDLE
   } state_t;

   localparam logic [DLY_W-1:0] LOW_LAST  = DLY_W'(RST_LOW_CYC - 1);
   localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'(RST_WAIT_CYC - 1);
   localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);

   state_t           state;
   logic [DLY_W-1:0] dly;
   logic [3:0]       idx;
   logic [2:0]       page;
   logic [6:0]       col;
   logic             fetch_wait;
   logic             pending;

   function automatic logic [7:0] init_byte(input logic [3:0] i);
      logic [7:0] b;
      case (i)
         4'd0:    b = 8'hE2;
         4'd1:    b = 8'hA2;
         4'd2:    b = 8'hA0;
         4'd3:    b = 8'hC8;
         4'd4:    b = 8'h2F;
         4'd5:    b = 8'h81;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         default: b = 8'hAF;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] page_byte(input logic [3:0] i,
                                            input logic [2:0] p);
      logic [7:0] b;
      case (i)
         4'd0:    b = {4'hB, 1'b0, p};
         4'd1:    b = 8'h10;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= HW_RST;
         dly        <= '0;
         idx        <= '0;
         page       <= '0;
         col        <= '0;
         fetch_wait <= 1'b0;
         pending    <= 1'b0;
         Start_Sig  <= 1'b0;
         SPI_Data   <= 10'h200;
         LCD_RSTn   <= 1'b0;
         Busy       <= 1'b1;
         Frame_Done <= 1'b0;
         Mem_Addr   <= '0;
      end else begin
         Frame_Done <= 1'b0;
         // Requests while busy collapse into one pending rewrite.
         if (Refresh_Sig && Busy)
            pending <= 1'b1;

         case (state)
            HW_RST: begin
               if (dly == LOW_LAST) begin
                  dly      <= '0;
                  LCD_RSTn <= 1'b1;
                  state    <= HW_WAIT;
               end else begin
                  dly <= dly + DLY_ONE;
               end
            end

            HW_WAIT: begin
               // The first command goes out on the terminal edge so
               // the post-reset wait is exactly RST_WAIT_CYC cycles.
               if (dly == WAIT_LAST) begin
                  dly       <= '0;
                  idx       <= '0;
                  Start_Sig <= 1'b1;
                  SPI_Data  <= {2'b00, init_byte(4'd0)};
                  state     <= INIT_CMD;
               end else begin
                  dly <= dly + DLY_ONE;
               end
            end

            INIT_CMD: begin
               if (!Start_Sig) begin
                  Start_Sig <= 1'b1;
                  SPI_Data  <= {2'b00, init_byte(idx)};
               end else if (Done_Sig) begin
                  Start_Sig <= 1'b0;
                  if (idx == 4'd8) begin
                     idx     <= '0;
                     page    <= '0;
                     // The power-up frame satisfies earlier requests.
                     pending <= 1'b0;
                     state   <= PAGE_CMD;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            PAGE_CMD: begin
               if (!Start_Sig) begin
                  Start_Sig <= 1'b1;
                  SPI_Data  <= {2'b00, page_byte(idx, page)};
               end else if (Done_Sig) begin
                  Start_Sig <= 1'b0;
                  if (idx == 4'd2) begin
                     idx        <= '0;
                     col        <= '0;
                     Mem_Addr   <= {page, 7'd0};
                     fetch_wait <= 1'b0;
                     state      <= FETCH;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            FETCH: begin
               // Address was registered on entry; data lands one
               // cycle later and is launched straight to the writer.
               if (!fetch_wait) begin
                  fetch_wait <= 1'b1;
               end else begin
                  fetch_wait <= 1'b0;
                  Start_Sig  <= 1'b1;
                  SPI_Data   <= {2'b01, Mem_Data};
                  state      <= DATA;
               end
            end

            DATA: begin
               if (Start_Sig && Done_Sig) begin
                  Start_Sig <= 1'b0;
                  if (col != 7'd127) begin
                     col      <= col + 7'd1;
                     Mem_Addr <= {page, col + 7'd1};
                     state    <= FETCH;
                  end else if (page != 3'd7) begin
                     page  <= page + 3'd1;
                     idx   <= '0;
                     state <= PAGE_CMD;
                  end else begin
                     Frame_Done <= 1'b1;
                     SPI_Data   <= 10'h200;
                     state      <= FRAME_END;
                  end
               end
            end

            FRAME_END: begin
               if (pending || Refresh_Sig) begin
                  pending <= 1'b0;
                  page    <= '0;
                  idx     <= '0;
                  state   <= PAGE_CMD;
               end else begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            IDLE: begin
               if (Refresh_Sig) begin
                  Busy  <= 1'b1;
                  page  <= '0;
                  idx   <= '0;
                  state <= PAGE_CMD;
               end
            end

            default: state <= HW_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd12864_frame_ctrl.sv
// tb_lcd12864_frame_ctrl: scoreboard bench for lcd12864_frame_ctrl with a
// synchronous display memory model and a fixed-latency byte writer model.
module tb_lcd12864_frame_ctrl;

   localparam int LOW  = 4;
   localparam int WAIT = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Refresh_Sig = 1'b0;
   logic       Busy;
   logic       Frame_Done;
   logic       LCD_RSTn;
   logic [9:0] Mem_Addr;
   logic [7:0] Mem_Data;
   logic       Start_Sig;
   logic [9:0] SPI_Data;
   logic       Done_Sig;

   logic       wr_done = 1'b0;
   logic       spur_done = 1'b0;
   logic       wr_busy = 1'b0;
   logic       start_q = 1'b0;
   int         wcnt = 0;

   logic [7:0] mem [1024];
   logic [7:0] init_cmds [9] = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h2F,
                                 8'h81, 8'h20, 8'h40, 8'hAF};

   int         checks = 0;
   int         errors = 0;
   int         req_cnt = 0;
   logic [9:0] exp_q [$];

   logic       prev_start = 1'b0;
   logic       prev_done = 1'b0;
   logic [9:0] prev_spi = 10'h200;
   logic       rst_q;

   assign Done_Sig = wr_done | spur_done;

   always #10 CLK = ~CLK;

   lcd12864_frame_ctrl #(
      .RST_LOW_CYC (LOW),
      .RST_WAIT_CYC(WAIT),
      .DLY_W       (18)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Refresh_Sig(Refresh_Sig),
      .Busy       (Busy),
      .Frame_Done (Frame_Done),
      .LCD_RSTn   (LCD_RSTn),
      .Mem_Addr   (Mem_Addr),
      .Mem_Data   (Mem_Data),
      .Start_Sig  (Start_Sig),
      .SPI_Data   (SPI_Data),
      .Done_Sig   (Done_Sig)
   );

   always @(posedge CLK) Mem_Data <= mem[Mem_Addr];
   always @(posedge CLK) rst_q <= RST;

   // Writer: Done_Sig visible 20 cycles after Start_Sig rises.
   always @(posedge CLK) begin
      start_q <= Start_Sig;
      wr_done <= 1'b0;
      if (RST) begin
         wr_busy <= 1'b0;
         wcnt    <= 0;
      end else if (wr_busy) begin
         if (wcnt == 19) begin
            wr_done <= 1'b1;
            wr_busy <= 1'b0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (Start_Sig && !start_q) begin
         wr_busy <= 1'b1;
         wcnt    <= 1;
      end
   end

   // Scoreboard and handshake monitor.
   always @(negedge CLK) begin
      logic [9:0] e;
      if (rst_q === 1'b0) begin
         if (prev_start) begin
            checks++;
            if (prev_done) begin
               if (Start_Sig !== 1'b0) begin
                  errors++;
                  $display("FAIL start_fall: Start_Sig=%b required 0", Start_Sig);
               end
            end else if (Start_Sig !== 1'b1 || SPI_Data !== prev_spi) begin
               errors++;
               $display("FAIL req_hold: Start_Sig=%b SPI_Data=%h required 1/%h",
                        Start_Sig, SPI_Data, prev_spi);
            end
         end
         if (Start_Sig === 1'b1 && !prev_start) begin
            checks++;
            req_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spi_seq: unexpected request %h", SPI_Data);
            end else begin
               e = exp_q.pop_front();
               if (SPI_Data !== e) begin
                  errors++;
                  $display("FAIL spi_seq: req %0d got %h required %h",
                           req_cnt, SPI_Data, e);
               end
            end
         end
      end
      prev_start = (Start_Sig === 1'b1);
      prev_done  = (Done_Sig === 1'b1);
      prev_spi   = SPI_Data;
   end

   task automatic push_init();
      for (int i = 0; i < 9; i++) exp_q.push_back({2'b00, init_cmds[i]});
   endtask

   task automatic push_page_cmds(input int p);
      exp_q.push_back({2'b00, 4'hB, 1'b0, 3'(p)});
      exp_q.push_back(10'h010);
      exp_q.push_back(10'h000);
   endtask

   task automatic push_frame();
      for (int p = 0; p < 8; p++) begin
         push_page_cmds(p);
         for (int c = 0; c < 128; c++)
            exp_q.push_back({2'b01, mem[p * 128 + c]});
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checks += 6;
      if (Start_Sig !== 1'b0) begin
         errors++; $display("FAIL rst_start: got %b required 0", Start_Sig);
      end
      if (SPI_Data !== 10'h200) begin
         errors++; $display("FAIL rst_spi: got %h required 200", SPI_Data);
      end
      if (LCD_RSTn !== 1'b0) begin
         errors++; $display("FAIL rst_lcdrst: got %b required 0", LCD_RSTn);
      end
      if (Busy !== 1'b1) begin
         errors++; $display("FAIL rst_busy: got %b required 1", Busy);
      end
      if (Frame_Done !== 1'b0) begin
         errors++; $display("FAIL rst_fdone: got %b required 0", Frame_Done);
      end
      if (Mem_Addr !== 10'd0) begin
         errors++; $display("FAIL rst_addr: got %h required 0", Mem_Addr);
      end
   endtask

   // Releases RST at a negedge and times the panel reset and wait phase.
   task automatic test_hw_reset_timing();
      int n;
      bit cs_bad;
      RST = 1'b0;
      n = 0;
      while (LCD_RSTn !== 1'b1 && n < 100) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n != LOW) begin
         errors++; $display("FAIL lcd_rst_low: got %0d cycles required %0d", n, LOW);
      end
      n = 0;
      cs_bad = 1'b0;
      while (Start_Sig !== 1'b1 && n < 100) begin
         if (SPI_Data !== 10'h200 || LCD_RSTn !== 1'b1) cs_bad = 1'b1;
         n++;
         @(negedge CLK);
      end
      checks += 3;
      if (n != WAIT) begin
         errors++; $display("FAIL hw_wait: got %0d cycles required %0d", n, WAIT);
      end
      if (cs_bad) begin
         errors++; $display("FAIL wait_idle_bus: got active bus required 200");
      end
      if (SPI_Data !== 10'h0E2) begin
         errors++; $display("FAIL first_cmd: got %h required 0e2", SPI_Data);
      end
   endtask

   task automatic test_frames_and_pending();
      int n;
      int fd;
      bit busy_drop;
      n = 0;
      while (Mem_Addr !== 10'd5 && n < 20000) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n >= 20000) begin
         errors++; $display("FAIL wait_col5: got timeout required addr 005");
      end
      // Spurious completion while the controller sits in its gap.
      spur_done = 1'b1;
      @(negedge CLK);
      spur_done = 1'b0;

      n = 0;
      while (Mem_Addr !== 10'd522 && n < 30000) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n >= 30000) begin
         errors++; $display("FAIL wait_page4: got timeout required addr 20a");
      end
      push_frame();
      for (int k = 0; k < 3; k++) begin
         Refresh_Sig = 1'b1;
         @(negedge CLK);
         Refresh_Sig = 1'b0;
         repeat (30) @(negedge CLK);
      end

      fd = 0;
      busy_drop = 1'b0;
      n = 0;
      while (fd < 2 && n < 60000) begin
         if (Busy !== 1'b1) busy_drop = 1'b1;
         if (Frame_Done === 1'b1) begin
            fd++;
            checks++;
            if (SPI_Data !== 10'h200) begin
               errors++; $display("FAIL fend_spi: got %h required 200", SPI_Data);
            end
         end
         if (fd < 2) begin
            n++;
            @(negedge CLK);
         end
      end
      checks += 2;
      if (n >= 60000) begin
         errors++; $display("FAIL wait_frames: got %0d frames required 2", fd);
      end
      if (busy_drop) begin
         errors++; $display("FAIL busy_between: got Busy=0 required 1");
      end
      @(negedge CLK);
      checks += 3;
      if (Busy !== 1'b0) begin
         errors++; $display("FAIL busy_fall: got %b required 0", Busy);
      end
      if (Frame_Done !== 1'b0) begin
         errors++; $display("FAIL fdone_width: got %b required 0", Frame_Done);
      end
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL frame_bytes: got %0d left required 0", exp_q.size());
      end
      repeat (5) begin
         @(negedge CLK);
         if (Frame_Done === 1'b1) fd++;
      end
      checks++;
      if (fd != 2) begin
         errors++; $display("FAIL fdone_count: got %0d required 2", fd);
      end
   endtask

   task automatic test_refresh_idle();
      int base;
      int n;
      checks++;
      if (Busy !== 1'b0) begin
         errors++; $display("FAIL idle_busy: got %b required 0", Busy);
      end
      base = req_cnt;
      push_page_cmds(0);
      exp_q.push_back({2'b01, mem[0]});
      exp_q.push_back({2'b01, mem[1]});
      Refresh_Sig = 1'b1;
      @(negedge CLK);
      Refresh_Sig = 1'b0;
      checks++;
      if (Busy !== 1'b1) begin
         errors++; $display("FAIL refresh_busy: got %b required 1", Busy);
      end
      n = 0;
      while (Start_Sig !== 1'b1 && n < 100) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (SPI_Data !== 10'h0B0) begin
         errors++; $display("FAIL refresh_first: got %h required 0b0", SPI_Data);
      end
      n = 0;
      while (req_cnt < base + 5 && n < 2000) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (n >= 2000) begin
         errors++; $display("FAIL refresh_reqs: got %0d required %0d", req_cnt - base, 5);
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      int base;
      int n;
      checks++;
      if (Start_Sig !== 1'b1 || SPI_Data[8] !== 1'b1) begin
         errors++; $display("FAIL mid_pre: got %b/%h required data request", Start_Sig, SPI_Data);
      end
      RST = 1'b1;
      exp_q.delete();
      push_init();
      push_page_cmds(0);
      base = req_cnt;
      @(negedge CLK);
      checks += 4;
      if (Start_Sig !== 1'b0) begin
         errors++; $display("FAIL mid_start: got %b required 0", Start_Sig);
      end
      if (LCD_RSTn !== 1'b0) begin
         errors++; $display("FAIL mid_lcdrst: got %b required 0", LCD_RSTn);
      end
      if (SPI_Data !== 10'h200) begin
         errors++; $display("FAIL mid_spi: got %h required 200", SPI_Data);
      end
      if (Busy !== 1'b1) begin
         errors++; $display("FAIL mid_busy: got %b required 1", Busy);
      end
      test_hw_reset_timing();
      n = 0;
      while (req_cnt < base + 12 && n < 2000) begin
         n++;
         @(negedge CLK);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL restart_seq: got %0d left required 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      test_reset();
      exp_q.delete();
      push_init();
      push_frame();
      test_hw_reset_timing();
      test_frames_and_pending();
      test_refresh_idle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(20 * 150000);
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

endmodule
